array_drain: RTL
================

ARRAY_DRAIN -- requirements
Module: array_drain

Interface
REQ-001 Parameter COLS, default 4: number of array columns drained; legal range 2..16.
REQ-002 Parameter ACCUM_WIDTH, default 32: signed width of each column result.
REQ-003 Parameter DEPTH, default 4: number of aligned-row FIFO entries; power of two, minimum 2.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-006 Yin  input  COLS*ACCUM_WIDTH  bottom-of-array partial sums, signed; column j occupies bits [j*ACCUM_WIDTH +: ACCUM_WIDTH].
REQ-007 Vin  input  1  column-0 result valid this cycle; column j's element of the same row is valid exactly j cycles later.
REQ-008 Yout  output  COLS*ACCUM_WIDTH  aligned result row at FIFO head, same packing as Yin.
REQ-009 out_valid  output  1  Yout holds a valid row.
REQ-010 out_ready  input  1  consumer accepts the row; transfer when out_valid and out_ready are both high at a rising edge.
REQ-011 ovf  output  1  sticky flag: at least one aligned row was dropped.
REQ-012 count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-013 Deskew: column j SHALL be delayed by COLS-1-j registers, so all columns of one row are coincident COLS-1 cycles after Vin; column COLS-1 is taken undelayed.
REQ-014 A COLS-1 stage valid shift register SHALL track Vin; its last stage is row_valid, coincident with the aligned row.
REQ-015 An aligned row with row_valid high SHALL be written into the FIFO at the same edge; Vin at edge t gives out_valid at edge t+COLS when the FIFO is empty (no bypass).
REQ-016 Back-to-back Vin on consecutive cycles SHALL produce consecutive rows in arrival order with no gaps or reordering.
REQ-017 FIFO full with row_valid high and no pop that cycle: the row SHALL be dropped, ovf set, and FIFO contents left unchanged.
REQ-018 FIFO full with simultaneous pop and push: both SHALL occur; count stays at DEPTH and ovf is unchanged.
REQ-019 FIFO empty: out_valid SHALL be 0 and Yout SHALL be all zeros; out_ready is then ignored.
REQ-020 count SHALL increment on push only, decrement on pop only, and hold on both or neither.
REQ-021 Pointers SHALL wrap modulo DEPTH.
REQ-022 Yout SHALL be stable while out_valid is high and out_ready is low.
REQ-023 Values SHALL be passed bit-exact (no arithmetic) unless REQ-028 applies.

Reset
REQ-024 RST high SHALL clear the FIFO pointers, count, valid shift register and ovf on the next edge; out_valid=0, Yout=0, count=0, ovf=0 in the following cycle.
REQ-025 Rows in flight in the deskew pipeline at reset SHALL be discarded; Vin pulses during reset SHALL be ignored.
REQ-026 Deskew data registers need not be reset; their contents SHALL never reach Yout without a matching valid.
REQ-027 ovf SHALL clear only on reset.

Configuration
REQ-028 With macro ARRAY_DRAIN_RELU_EN defined, each column of the aligned row SHALL be clamped to 0 if negative before the FIFO write.
REQ-029 Without ARRAY_DRAIN_RELU_EN, rows SHALL be stored unmodified; there SHALL be no other behavioural difference.

Verification (COLS=4, DEPTH=4, ACCUM_WIDTH=32)
REQ-030 Single row: Vin at edge 0 with column j = 10+j presented at edge j -> out_valid at edge 4, Yout = {13,12,11,10}, out_ready=1 -> out_valid=0 at edge 5.
REQ-031 Burst: 6 consecutive rows with out_ready=0 -> count saturates at 4, rows 5 and 6 dropped, ovf=1; drain shows rows 1-4 in order.
REQ-032 Full with simultaneous push and pop: out_ready=1 as the 5th row aligns -> count stays 4, ovf=0, row 5 is later delivered.
REQ-033 Backpressure: out_ready toggled 1010 over a 4-row stream -> every row delivered exactly once, Yout stable while stalled.
REQ-034 Reset mid-operation: RST at edge 2 after Vin at edge 0 -> no row emitted, count=0, ovf=0.
REQ-035 Column values -5 and 7 -> output -5 and 7 without ARRAY_DRAIN_RELU_EN, 0 and 7 with it.

Source files
------------

// File: rtl/array_drain.sv
// rtl/array_drain.sv - deskews systolic-array column outputs into aligned rows and queues them in a FIFO
// Optional build macro: ARRAY_DRAIN_RELU_EN (clamp negative columns to zero before the FIFO write).
module array_drain #(
  parameter int COLS        = 4,
  parameter int ACCUM_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [COLS*ACCUM_WIDTH-1:0]   Yin,
  input  logic                          Vin,
  output logic [COLS*ACCUM_WIDTH-1:0]   Yout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          ovf,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int ROW_W = COLS * ACCUM_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SKEW  = COLS - 1;

  logic [SKEW-1:0]  vld_sr;
  logic             row_valid;
  logic [ROW_W-1:0] aligned_row;
  logic [ROW_W-1:0] store_row;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Valid tracker: Vin travels the same COLS-1 stages as column 0's data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= Vin;
      for (int k = 1; k < SKEW; k++) begin
        vld_sr[k] <= vld_sr[k-1];
      end
    end
  end

  assign row_valid = vld_sr[SKEW-1];

  // Column j waits COLS-1-j cycles so every column of a row lands together.
  genvar gj;
  generate
    for (gj = 0; gj < COLS - 1; gj++) begin : g_skew
      localparam int NREG = COLS - 1 - gj;
      logic [ACCUM_WIDTH-1:0] dly [NREG];

      // Per-column delay line; data only, validity comes from vld_sr.
      always_ff @(posedge CLK) begin
        dly[0] <= Yin[gj*ACCUM_WIDTH +: ACCUM_WIDTH];
        for (int k = 1; k < NREG; k++) begin
          dly[k] <= dly[k-1];
        end
      end

      assign aligned_row[gj*ACCUM_WIDTH +: ACCUM_WIDTH] = dly[NREG-1];
    end
  endgenerate

  // The last column arrives latest, so it is used straight from the input.
  assign aligned_row[(COLS-1)*ACCUM_WIDTH +: ACCUM_WIDTH] =
    Yin[(COLS-1)*ACCUM_WIDTH +: ACCUM_WIDTH];

  // Row value as stored: optionally rectified per column.
  always_comb begin
    store_row = aligned_row;
`ifdef ARRAY_DRAIN_RELU_EN
    for (int c = 0; c < COLS; c++) begin
      if (aligned_row[c*ACCUM_WIDTH + ACCUM_WIDTH - 1]) begin
        store_row[c*ACCUM_WIDTH +: ACCUM_WIDTH] = '0;
      end
    end
`endif
  end

  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign out_valid = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = row_valid & (~full | pop);
  assign drop      = row_valid & full & ~pop;
  assign Yout      = out_valid ? mem[rd_ptr] : '0;

  // Row storage; entries are only visible through count, so no reset needed.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= store_row;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule
